wbu_pipe: RTL

WBU_PIPE -- requirements
Module: wbu_pipe

---
 rtl/wbu_pkg.sv | 57 +++++
 rtl/wbu_fifo.sv | 88 ++++++++
 rtl/wbu_pipe.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/wbu_pkg.sv
// wbu_pkg: shared definitions for the write-back buffer.
//   - Width macros (used only when no global definition already exists)
//   - Write-source select codes
//   - Buffered entry type {wr_en, id, data}
//   - Write-data selection helper used at enqueue time

`ifndef ARGS_WIDTH
`define ARGS_WIDTH 3
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif
`ifndef DATA_ZERO
`define DATA_ZERO {`DATA_WIDTH{1'b0}}
`endif

package wbu_pkg;

    localparam logic [`ARGS_WIDTH-1:0] REG_WR_SRC_ALU = `ARGS_WIDTH'd0;
    localparam logic [`ARGS_WIDTH-1:0] REG_WR_SRC_MEM = `ARGS_WIDTH'd1;
    localparam logic [`ARGS_WIDTH-1:0] REG_WR_SRC_PC  = `ARGS_WIDTH'd2;
    localparam logic [`ARGS_WIDTH-1:0] REG_WR_SRC_CSR = `ARGS_WIDTH'd3;

    typedef struct packed {
        logic                   wr_en;
        logic [`GPRS_WIDTH-1:0] id;
        logic [`DATA_WIDTH-1:0] data;
    } wbu_entry_t;

    // Resolve the final GPR write value before the entry is buffered, so the
    // buffer only ever holds one data word per entry.
    function automatic logic [`DATA_WIDTH-1:0] sel_wr_data(
        input logic [`ARGS_WIDTH-1:0] src,
        input logic [`ADDR_WIDTH-1:0] pc,
        input logic [31:0]            pc_step,
        input logic [`DATA_WIDTH-1:0] alu_res,
        input logic [`DATA_WIDTH-1:0] ram_res,
        input logic [`DATA_WIDTH-1:0] csr_res
    );
        logic [`ADDR_WIDTH-1:0] link;
        link = pc + `ADDR_WIDTH'(pc_step);
        case (src)
            REG_WR_SRC_ALU: return alu_res;
            REG_WR_SRC_MEM: return ram_res;
            REG_WR_SRC_PC:  return `DATA_WIDTH'(link);
            REG_WR_SRC_CSR: return csr_res;
            default:        return `DATA_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/wbu_fifo.sv
// wbu_fifo: circular buffer of write-back entries.
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_push          store i_push_entry at the tail (caller never pushes when full)
//   i_pop           drop the head entry (caller never pops when empty)
//   o_head          oldest entry
//   o_count         number of occupied entries
//   o_rd_ptr        slot index of the oldest entry
//   o_valid         per-slot occupancy
//   o_entries       per-slot contents, for the forwarding search

`ifndef ARGS_WIDTH
`define ARGS_WIDTH 3
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif

module wbu_fifo
    import wbu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  wbu_entry_t                   i_push_entry,
    input  logic                         i_pop,
    output wbu_entry_t                   o_head,
    output logic [CW-1:0]                o_count,
    output logic [PW-1:0]                o_rd_ptr,
    output logic [DEPTH-1:0]             o_valid,
    output wbu_entry_t [DEPTH-1:0]       o_entries
);

    wbu_entry_t        r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH.
            if (i_push) begin
                r_wr_ptr          <= r_wr_ptr + PW'(1);
                r_valid[r_wr_ptr] <= 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr          <= r_rd_ptr + PW'(1);
                r_valid[r_rd_ptr] <= 1'b0;
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    // NOTE: the storage array is deliberately not reset; the valid bits and
    // count say which slots mean anything, so stale data is never observed.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entries
        assign o_entries[g] = r_mem[g];
    end

    assign o_head   = r_mem[r_rd_ptr];
    assign o_count  = r_count;
    assign o_rd_ptr = r_rd_ptr;
    assign o_valid  = r_valid;

endmodule

// File: rtl/wbu_pipe.sv
// wbu_pipe: buffered write-back stage with GPR forwarding.
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_l2w_*                 upstream entry; accepted when i_l2w_valid && o_wbu_ready
//   i_rf_ready              register-file write port available this cycle
//   o_wbu_valid/pc_en       head entry retires this cycle
//   o_wbu_gpr_wr_*          GPR write of the retiring entry (zero otherwise)
//   i_hzd_rs*_id            hazard query register IDs
//   o_wbu_fwd_rs*_hit/data  youngest buffered matching write
//   o_wbu_count             occupied entries
//   o_wbu_instret           retired-instruction counter

`ifndef ARGS_WIDTH
`define ARGS_WIDTH 3
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif

module wbu_pipe
    import wbu_pkg::*;
#(
    parameter  int          DEPTH   = 2,
    parameter  logic [31:0] PC_STEP = 32'h4,
    localparam int          PW      = $clog2(DEPTH),
    localparam int          CW      = PW + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_l2w_valid,
    output logic                   o_wbu_ready,
    input  logic                   i_l2w_ctr_reg_wr_en,
    input  logic [`ARGS_WIDTH-1:0] i_l2w_ctr_reg_wr_src,
    input  logic [`ADDR_WIDTH-1:0] i_l2w_pc,
    input  logic [`DATA_WIDTH-1:0] i_l2w_alu_res,
    input  logic [`DATA_WIDTH-1:0] i_l2w_ram_res,
    input  logic [`DATA_WIDTH-1:0] i_l2w_csr_res,
    input  logic [`GPRS_WIDTH-1:0] i_l2w_gpr_wr_id,
    input  logic                   i_rf_ready,
    output logic                   o_wbu_valid,
    output logic                   o_wbu_gpr_wr_en,
    output logic [`GPRS_WIDTH-1:0] o_wbu_gpr_wr_id,
    output logic [`DATA_WIDTH-1:0] o_wbu_gpr_wr_data,
    output logic                   o_wbu_pc_en,
    input  logic [`GPRS_WIDTH-1:0] i_hzd_rs1_id,
    input  logic [`GPRS_WIDTH-1:0] i_hzd_rs2_id,
    output logic                   o_wbu_fwd_rs1_hit,
    output logic                   o_wbu_fwd_rs2_hit,
    output logic [`DATA_WIDTH-1:0] o_wbu_fwd_rs1_data,
    output logic [`DATA_WIDTH-1:0] o_wbu_fwd_rs2_data,
    output logic [CW-1:0]          o_wbu_count,
    output logic [63:0]            o_wbu_instret
);

    wbu_entry_t               w_push_entry;
    wbu_entry_t               w_head;
    wbu_entry_t [DEPTH-1:0]   w_entries;
    logic [DEPTH-1:0]         w_valid;
    logic [CW-1:0]            w_count;
    logic [PW-1:0]            w_rd_ptr;
    logic                     w_accept;
    logic                     w_retire;
    logic [63:0]              r_instret;

    // Ready depends on registered occupancy only: a full buffer refuses input
    // even if the head drains this cycle, keeping i_rf_ready off this path.
    assign o_wbu_ready = (w_count < CW'(DEPTH));
    assign w_accept    = i_l2w_valid && o_wbu_ready;
    // Retirement is suppressed during reset so flushed entries never write.
    assign w_retire    = !i_rst && (w_count != '0) && i_rf_ready;

    assign w_push_entry = '{
        wr_en: i_l2w_ctr_reg_wr_en,
        id:    i_l2w_gpr_wr_id,
        data:  sel_wr_data(i_l2w_ctr_reg_wr_src, i_l2w_pc, PC_STEP,
                           i_l2w_alu_res, i_l2w_ram_res, i_l2w_csr_res)
    };

    wbu_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (w_accept),
        .i_push_entry (w_push_entry),
        .i_pop        (w_retire),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_rd_ptr     (w_rd_ptr),
        .o_valid      (w_valid),
        .o_entries    (w_entries)
    );

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_wbu_valid       = 1'b0;
        o_wbu_pc_en       = 1'b0;
        o_wbu_gpr_wr_en   = 1'b0;
        o_wbu_gpr_wr_id   = '0;
        o_wbu_gpr_wr_data = '0;
        if (w_retire) begin
            o_wbu_valid       = 1'b1;
            o_wbu_pc_en       = 1'b1;
            o_wbu_gpr_wr_en   = w_head.wr_en && (w_head.id != '0);
            o_wbu_gpr_wr_id   = w_head.id;
            o_wbu_gpr_wr_data = w_head.data;
        end
    end

    // Walk the ring oldest to youngest so a later match overrides an earlier
    // one; the entry being accepted this cycle is not yet stored, so it is
    // naturally excluded.
    always_comb begin
        logic [PW-1:0] idx;
        wbu_entry_t    ent;
        idx                = '0;
        ent                = '0;
        o_wbu_fwd_rs1_hit  = 1'b0;
        o_wbu_fwd_rs2_hit  = 1'b0;
        o_wbu_fwd_rs1_data = '0;
        o_wbu_fwd_rs2_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = w_rd_ptr + PW'(k);
            ent = w_entries[idx];
            if (w_valid[idx] && ent.wr_en && (ent.id != '0)) begin
                if (ent.id == i_hzd_rs1_id) begin
                    o_wbu_fwd_rs1_hit  = 1'b1;
                    o_wbu_fwd_rs1_data = ent.data;
                end
                if (ent.id == i_hzd_rs2_id) begin
                    o_wbu_fwd_rs2_hit  = 1'b1;
                    o_wbu_fwd_rs2_data = ent.data;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign o_wbu_count   = w_count;
    assign o_wbu_instret = r_instret;

endmodule
